// File: rtl/watch_pkg.sv
// Shared types, field moduli and wrap arithmetic for the watch time controller.
package watch_pkg;

   typedef enum logic [1:0] {
      MODE_RUN     = 2'b00,
      MODE_SET_MIN = 2'b01,
      MODE_SET_HR  = 2'b10
   } mode_t;

   localparam int SEC_MOD = 60;
   localparam int MIN_MOD = 60;
   localparam int HR_MOD  = 24;
   localparam int SEC_W   = 6;
   localparam int MIN_W   = 6;
   localparam int HR_W    = 5;
   localparam int CNT_W   = 32;

   typedef struct packed {
      logic [SEC_W-1:0] secs;
      logic [MIN_W-1:0] mins;
      logic [HR_W-1:0]  hrs;
   } watch_time_t;

   // Out-of-range values fall into the ">= modulus-1" test and wrap to zero.
   function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] modulus);
      logic [5:0] result;
      if (value >= modulus - 6'd1) begin
         result = 6'd0;
      end else begin
         result = value + 6'd1;
      end
      return result;
   endfunction

   function automatic logic [5:0] wrap_dec(input logic [5:0] value, input logic [5:0] modulus);
      logic [5:0] result;
      if (value == 6'd0) begin
         result = modulus - 6'd1;
      end else begin
         result = value - 6'd1;
      end
      return result;
   endfunction

   // One-second advance with the full seconds -> minutes -> hours carry chain.
   function automatic watch_time_t tick_advance(input watch_time_t t);
      watch_time_t n;
      n      = t;
      n.secs = wrap_inc(t.secs, 6'(SEC_MOD));
      if (t.secs >= 6'(SEC_MOD - 1)) begin
         n.mins = wrap_inc(t.mins, 6'(MIN_MOD));
         if (t.mins >= 6'(MIN_MOD - 1)) begin
            n.hrs = 5'(wrap_inc({1'b0, t.hrs}, 6'(HR_MOD)));
         end else begin
            n.hrs = t.hrs;
         end
      end else begin
         n.mins = t.mins;
      end
      return n;
   endfunction

endpackage

// File: rtl/watch_time_controller_button_conditioner.sv
// Raw pushbutton conditioner: 2-flop synchroniser, debounce, press pulse and auto-repeat.
module button_conditioner
   import watch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000
) (
   input  logic userclock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press,
   output logic fire
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [1:0]       sync_r;
   logic             stable_r, stable_s;
   logic [CNT_W-1:0] deb_r, deb_s;
   logic [CNT_W-1:0] hold_r, hold_s;
   logic             repeating_r, repeating_s;
   logic             press_r, press_s;
   logic             rpt_s;
   logic             fire_r;

   // Debounce: the stable level only flips after an unbroken run of disagreeing cycles.
   always_comb begin
      deb_s    = deb_r;
      stable_s = stable_r;
      press_s  = 1'b0;
      if (sync_r[1] == stable_r) begin
         deb_s = CNT_ZERO;
      end else if (deb_r >= DEB_LAST) begin
         stable_s = sync_r[1];
         deb_s    = CNT_ZERO;
         press_s  = sync_r[1];
      end else begin
         deb_s = deb_r + CNT_ONE;
      end
   end

   // Auto-repeat: one long initial hold interval, then a shorter repeat interval.
   always_comb begin
      hold_s      = hold_r;
      repeating_s = repeating_r;
      rpt_s       = 1'b0;
      if (!stable_r) begin
         hold_s      = CNT_ZERO;
         repeating_s = 1'b0;
      end else if (!repeating_r) begin
         if (hold_r >= HOLD_LAST) begin
            hold_s      = CNT_ZERO;
            repeating_s = 1'b1;
            rpt_s       = 1'b1;
         end else begin
            hold_s = hold_r + CNT_ONE;
         end
      end else begin
         if (hold_r >= REP_LAST) begin
            hold_s = CNT_ZERO;
            rpt_s  = 1'b1;
         end else begin
            hold_s = hold_r + CNT_ONE;
         end
      end
   end

   // Conditioner state and registered pulse outputs.
   always_ff @(posedge userclock) begin
      if (reset) begin
         sync_r      <= 2'b00;
         stable_r    <= 1'b0;
         deb_r       <= CNT_ZERO;
         hold_r      <= CNT_ZERO;
         repeating_r <= 1'b0;
         press_r     <= 1'b0;
         fire_r      <= 1'b0;
      end else begin
         sync_r      <= {sync_r[0], raw};
         stable_r    <= stable_s;
         deb_r       <= deb_s;
         hold_r      <= hold_s;
         repeating_r <= repeating_s;
         press_r     <= press_s;
         fire_r      <= press_s | rpt_s;
      end
   end

   assign level = stable_r;
   assign press = press_r;
   assign fire  = fire_r;

endmodule

// File: rtl/watch_time_controller.sv
// Watch time registers with a run/set mode FSM driven by the 1 Hz tick and conditioned buttons.
module watch_time_controller
   import watch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000
) (
   input  logic       userclock,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       switch,
   input  logic       switch2,
   input  logic       button0,
   input  logic       button2,
   input  logic       button3,
   output logic [5:0] seconds,
   output logic [5:0] minutes,
   output logic [4:0] hours,
   output logic [1:0] mode,
   output logic       blink
);

   logic        b0_level_s, b0_press_s, b0_fire_s;
   logic        b2_level_s, b2_press_s, b2_fire_s;
   logic        b3_level_s, b3_press_s, b3_fire_s;
   logic        inc_s, dec_s, sw_block_s;
   logic        unused_s;
   mode_t       mode_r;
   watch_time_t time_r;
   logic        blink_r;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
   ) u_btn0 (
      .userclock(userclock), .reset(reset), .raw(button0),
      .level(b0_level_s), .press(b0_press_s), .fire(b0_fire_s)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
   ) u_btn2 (
      .userclock(userclock), .reset(reset), .raw(button2),
      .level(b2_level_s), .press(b2_press_s), .fire(b2_fire_s)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
   ) u_btn3 (
      .userclock(userclock), .reset(reset), .raw(button3),
      .level(b3_level_s), .press(b3_press_s), .fire(b3_fire_s)
   );

   // Mode only follows button0 presses; the other conditioner outputs are deliberately unused.
   assign unused_s   = ^{b0_level_s, b0_fire_s, b2_level_s, b2_press_s, b3_level_s, b3_press_s};
   assign inc_s      = b2_fire_s & ~b3_fire_s;
   assign dec_s      = b3_fire_s & ~b2_fire_s;
   assign sw_block_s = switch | switch2;

   // Mode FSM together with the time and blink registers it arbitrates.
   always_ff @(posedge userclock) begin
      if (reset) begin
         mode_r  <= MODE_RUN;
         time_r  <= {6'd0, 6'd0, 5'd0};
         blink_r <= 1'b0;
      end else begin
         case (mode_r)
            MODE_RUN: begin
               blink_r <= 1'b0;
               if (b0_press_s && !sw_block_s) begin
                  mode_r      <= MODE_SET_MIN;
                  time_r.secs <= 6'd0;
               end else if (tick_1hz) begin
                  time_r <= tick_advance(time_r);
               end
            end
            MODE_SET_MIN: begin
               if (sw_block_s) begin
                  mode_r  <= MODE_RUN;
                  blink_r <= 1'b0;
               end else begin
                  time_r.secs <= 6'd0;
                  blink_r     <= blink_r ^ tick_1hz;
                  if (inc_s) begin
                     time_r.mins <= wrap_inc(time_r.mins, 6'(MIN_MOD));
                  end else if (dec_s) begin
                     time_r.mins <= wrap_dec(time_r.mins, 6'(MIN_MOD));
                  end
                  if (b0_press_s) begin
                     mode_r <= MODE_SET_HR;
                  end
               end
            end
            MODE_SET_HR: begin
               if (sw_block_s) begin
                  mode_r  <= MODE_RUN;
                  blink_r <= 1'b0;
               end else begin
                  time_r.secs <= 6'd0;
                  if (inc_s) begin
                     time_r.hrs <= 5'(wrap_inc({1'b0, time_r.hrs}, 6'(HR_MOD)));
                  end else if (dec_s) begin
                     time_r.hrs <= 5'(wrap_dec({1'b0, time_r.hrs}, 6'(HR_MOD)));
                  end
                  if (b0_press_s) begin
                     mode_r  <= MODE_RUN;
                     blink_r <= 1'b0;
                  end else begin
                     blink_r <= blink_r ^ tick_1hz;
                  end
               end
            end
            default: begin
               mode_r  <= MODE_RUN;
               blink_r <= 1'b0;
            end
         endcase
      end
   end

   assign seconds = time_r.secs;
   assign minutes = time_r.mins;
   assign hours   = time_r.hrs;
   assign mode    = mode_r;
   assign blink   = blink_r;

endmodule

// File: tb/tb_watch_time_controller.sv
// Scoreboard bench: stimulus queues edge-stamped expected states, a negedge monitor compares them.
module tb_watch_time_controller;

   logic       userclock = 1'b0;
   logic       reset     = 1'b1;
   logic       tick_1hz  = 1'b0;
   logic       switch    = 1'b0;
   logic       switch2   = 1'b0;
   logic       button0   = 1'b0;
   logic       button2   = 1'b0;
   logic       button3   = 1'b0;
   logic [5:0] seconds, minutes;
   logic [4:0] hours;
   logic [1:0] mode;
   logic       blink;

   typedef struct {
      int          edge_no;
      logic [95:0] tag;
      logic [5:0]  sec;
      logic [5:0]  mins;
      logic [4:0]  hrs;
      logic [1:0]  md;
      logic        bl;
   } exp_t;

   exp_t       exp_q[$];
   int         edge_cnt = 0;
   int         checks   = 0;
   int         failures = 0;
   logic [5:0] m_sec    = 6'd0;
   logic [5:0] m_min    = 6'd0;
   logic [4:0] m_hr     = 5'd0;
   logic [1:0] m_mode   = 2'b00;
   logic       m_blink  = 1'b0;

   watch_time_controller #(
      .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
   ) dut (
      .userclock(userclock), .reset(reset), .tick_1hz(tick_1hz),
      .switch(switch), .switch2(switch2),
      .button0(button0), .button2(button2), .button3(button3),
      .seconds(seconds), .minutes(minutes), .hours(hours),
      .mode(mode), .blink(blink)
   );

   always #5 userclock = ~userclock;

   always @(posedge userclock) edge_cnt <= edge_cnt + 1;

   // Monitor: compare every queued expectation stamped with the edge just taken.
   always @(negedge userclock) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].edge_no == edge_cnt) begin
            exp_t e;
            e = exp_q[i];
            checks++;
            if ({seconds, minutes, hours, mode, blink} !== {e.sec, e.mins, e.hrs, e.md, e.bl}) begin
               failures++;
               $display("FAIL %0s edge=%0d got %0d:%0d:%0d mode=%0d blink=%0d want %0d:%0d:%0d mode=%0d blink=%0d",
                        e.tag, edge_cnt, hours, minutes, seconds, mode, blink,
                        e.hrs, e.mins, e.sec, e.md, e.bl);
            end
            exp_q.delete(i);
         end
      end
   end

   task automatic push(input int e, input logic [95:0] tag);
      exp_t x;
      x.edge_no = e;
      x.tag     = tag;
      x.sec     = m_sec;
      x.mins    = m_min;
      x.hrs     = m_hr;
      x.md      = m_mode;
      x.bl      = m_blink;
      exp_q.push_back(x);
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge userclock);
      #1;
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         0: button0 = v;
         2: button2 = v;
         3: button3 = v;
         default: ;
      endcase
   endtask

   task automatic press(input int which, input int hold, input int gap);
      set_btn(which, 1'b1);
      wait_edges(hold);
      set_btn(which, 1'b0);
      wait_edges(gap);
   endtask

   task automatic tick_pulse();
      tick_1hz = 1'b1;
      wait_edges(1);
      tick_1hz = 1'b0;
      wait_edges(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog edge=%0d", edge_cnt);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      push(1, "reset");
      push(2, "reset_hold");
      wait_edges(2);
      reset = 1'b0;

      // Walk the clock to 23:59:58 through set mode and ticks, then roll over.
      m_mode = 2'b01; push(edge_cnt + 7, "enter_min"); press(0, 10, 10);
      m_min = 6'd59;  push(edge_cnt + 7, "setup_min"); press(3, 10, 10);
      m_mode = 2'b10; push(edge_cnt + 7, "enter_hr");  press(0, 10, 10);
      m_hr = 5'd23;   push(edge_cnt + 7, "setup_hr");  press(3, 10, 10);
      m_mode = 2'b00; push(edge_cnt + 7, "exit_run");  press(0, 10, 10);
      repeat (57) tick_pulse();
      m_sec = 6'd58; push(edge_cnt + 1, "sec58");   tick_pulse();
      m_sec = 6'd59; push(edge_cnt + 1, "roll_59"); tick_pulse();
      m_sec = 6'd0; m_min = 6'd0; m_hr = 5'd0;
      push(edge_cnt + 1, "roll_00"); tick_pulse();

      // Set-mode entry clears seconds; ticks then only toggle blink.
      repeat (36) tick_pulse();
      m_sec = 6'd37; push(edge_cnt + 1, "sec37"); tick_pulse();
      push(edge_cnt + 6, "pre_entry");
      m_mode = 2'b01; m_sec = 6'd0;
      push(edge_cnt + 7, "entry_sec0"); press(0, 10, 10);
      m_blink = 1'b1; push(edge_cnt + 1, "blink_on");  tick_pulse();
      m_blink = 1'b0; push(edge_cnt + 1, "blink_off"); tick_pulse();
      m_blink = 1'b1; push(edge_cnt + 1, "blink_on2"); tick_pulse();

      // Minute wrap in both directions, no carry into hours.
      m_min = 6'd59; push(edge_cnt + 7, "min_dn_wrap");  press(3, 10, 10);
      m_min = 6'd0;  push(edge_cnt + 7, "min_up_wrap");  press(2, 10, 10);
      m_min = 6'd59; push(edge_cnt + 7, "min_dn_again"); press(3, 10, 10);

      // Hours auto-repeat from 22; debounced release keeps repeating until level drops.
      m_mode = 2'b10; push(edge_cnt + 7, "to_set_hr");  press(0, 10, 10);
      m_hr = 5'd23;   push(edge_cnt + 7, "hr_dn_wrap"); press(3, 10, 10);
      m_hr = 5'd22;   push(edge_cnt + 7, "hr_22");      press(3, 10, 10);
      e0 = edge_cnt;
      m_hr = 5'd23; push(e0 + 7, "rep_press"); push(e0 + 26, "rep_wait");
      m_hr = 5'd0;  push(e0 + 27, "rep_1");
      m_hr = 5'd1;  push(e0 + 32, "rep_2");
      m_hr = 5'd2;  push(e0 + 37, "rep_3");
      m_hr = 5'd3;  push(e0 + 42, "rep_4");
      m_hr = 5'd4;  push(e0 + 47, "rep_5"); push(e0 + 52, "rep_stop");
      press(2, 40, 15);

      // Three-cycle glitch and simultaneous inc/dec leave the field alone.
      e0 = edge_cnt;
      push(e0 + 8, "glitch_a"); push(e0 + 12, "glitch_b");
      press(2, 3, 12);
      e0 = edge_cnt;
      push(e0 + 7, "both_a"); push(e0 + 10, "both_b");
      button2 = 1'b1; button3 = 1'b1;
      wait_edges(10);
      button2 = 1'b0; button3 = 1'b0;
      wait_edges(10);

      // Back to RUN, inc ignored there, then switch override and blocked entry.
      m_mode = 2'b00; m_blink = 1'b0; push(edge_cnt + 7, "hr_to_run"); press(0, 10, 10);
      push(edge_cnt + 7, "run_ignore_inc"); press(2, 10, 10);
      m_mode = 2'b01; push(edge_cnt + 7, "run_to_min"); press(0, 10, 10);
      m_blink = 1'b1; push(edge_cnt + 1, "blink_min"); tick_pulse();
      e0 = edge_cnt;
      m_mode = 2'b00; m_blink = 1'b0; push(e0 + 7, "override");
      button0 = 1'b1;
      wait_edges(6);
      switch2 = 1'b1;
      wait_edges(4);
      button0 = 1'b0;
      wait_edges(10);
      push(edge_cnt + 7, "blocked_sw2"); press(0, 10, 10);
      switch2 = 1'b0;
      switch  = 1'b1;
      push(edge_cnt + 7, "blocked_sw1"); press(0, 10, 10);
      switch  = 1'b0;

      // Reset in the middle of minute auto-repeat.
      m_mode = 2'b01; push(edge_cnt + 7, "pre_rst_min"); press(0, 10, 10);
      e0 = edge_cnt;
      m_min = 6'd0; push(e0 + 7, "rst_press");
      m_min = 6'd1; push(e0 + 27, "rst_rep"); push(e0 + 29, "rst_pre");
      m_sec = 6'd0; m_min = 6'd0; m_hr = 5'd0; m_mode = 2'b00; m_blink = 1'b0;
      push(e0 + 30, "rst_hit"); push(e0 + 31, "rst_hold");
      push(e0 + 32, "rst_release"); push(e0 + 36, "rst_after");
      button2 = 1'b1;
      wait_edges(29);
      reset = 1'b1;
      wait_edges(2);
      reset = 1'b0;
      wait_edges(2);
      button2 = 1'b0;
      wait_edges(20);

      checks++;
      if (seconds !== 6'd0) begin
         failures++;
         $display("FAIL final seconds=%0d", seconds);
      end
      checks++;
      if (minutes !== 6'd0) begin
         failures++;
         $display("FAIL final minutes=%0d", minutes);
      end
      checks++;
      if (hours !== 5'd0) begin
         failures++;
         $display("FAIL final hours=%0d", hours);
      end
      checks++;
      if (mode !== 2'b00) begin
         failures++;
         $display("FAIL final mode=%0d", mode);
      end
      checks++;
      if (blink !== 1'b0) begin
         failures++;
         $display("FAIL final blink=%0d", blink);
      end

      while (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL missed %0s edge=%0d now=%0d", exp_q[0].tag, exp_q[0].edge_no, edge_cnt);
         exp_q.delete(0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/watch_time_controller.md
Name: watch_time_controller

Overview:
- Owns the running watch time registers (seconds, minutes, hours) and arbitrates between two sources of change: the 1 Hz timebase tick and user set-buttons.
- Sequences run/set modes with a small FSM.
- Conditions raw pushbuttons: synchronise, debounce, edge-detect, auto-repeat.
- Feeds the display mux and the alarm comparator.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synced cycles required before a button level is accepted.
- HOLD_CYCLES, 25000000, cycles a conditioned button must stay high before auto-repeat starts.
- REPEAT_CYCLES, 5000000, cycles between auto-repeat pulses once repeating.

Ports:
- userclock  in  1  system clock; every flop in the block is clocked by it.
- reset  in  1  synchronous, active-high reset.
- tick_1hz  in  1  single-cycle enable, once per second, synchronous to userclock.
- switch  in  1  display-select switch; must be low to permit set mode.
- switch2  in  1  display-select switch; must be low to permit set mode.
- button0  in  1  raw mode button (asynchronous).
- button2  in  1  raw increment button (asynchronous).
- button3  in  1  raw decrement button (asynchronous).
- seconds  out  6  0..59.
- minutes  out  6  0..59.
- hours  out  5  0..23.
- mode  out  2  00 RUN, 01 SET_MIN, 10 SET_HR; 11 never driven.
- blink  out  1  digit-blink enable for the field being set.

Behaviour:
- Reset (synchronous, active-high) clears the following; all take effect at the first edge with reset high:
  - seconds, minutes, hours, blink: 0.
  - mode: RUN.
  - Conditioners: every stable level 0, every counter 0.
- Button conditioning, one instance per button:
  - Input is synchronised through a 2-flop synchroniser.
  - The stable level flips after DEBOUNCE_CYCLES consecutive cycles in which the synced value differs from the stable level. Any agreeing cycle zeroes the counter.
  - press: 1-cycle pulse on a stable 0->1 transition.
  - Auto-repeat:
    - While the stable level is high, a hold counter runs.
    - Reaching HOLD_CYCLES emits one repeat pulse.
    - After that, one repeat pulse every REPEAT_CYCLES cycles.
    - Stable level low clears the hold counter.
  - Fire pulse = press OR repeat pulse.
- Mode FSM (advanced only by button0 press; button0 auto-repeat pulses are ignored):
  - RUN -> SET_MIN on button0 press, only if switch=0 and switch2=0. On that entry edge seconds is cleared to 0.
  - SET_MIN -> SET_HR on button0 press.
  - SET_HR -> RUN on button0 press.
  - Either switch going high while in SET_MIN or SET_HR forces RUN on the next edge. This overrides any button event in the same cycle.
- RUN mode:
  - On tick_1hz, seconds increments.
  - Rollover chain: 59->0 carries into minutes; minutes 59->0 carries into hours; hours 23->0. Whole chain updates in the same cycle.
  - button2 and button3 fire pulses are ignored.
  - blink=0.
- SET_MIN / SET_HR modes:
  - tick_1hz does not advance time; seconds holds at 0.
  - blink toggles on each tick_1hz.
  - blink forced to 0 on every transition into RUN.
  - button2 fire: selected field +1, wrapping 59->0 (min) or 23->0 (hr). No carry into the other field.
  - button3 fire: selected field -1, wrapping 0->59 or 0->23. No borrow.
  - button2 and button3 fire in the same cycle: no change.
- Latency and simultaneous events:
  - A field update is visible on the clock edge after the fire pulse.
  - Raw button held high from cycle 0 gives the update at edge DEBOUNCE_CYCLES+3 (2 sync + debounce + 1 update).
  - button0 press and an inc/dec fire in the same cycle: inc/dec applies to the field of the current (pre-transition) mode, then the mode advances.
  - Reset mid-set: returns to RUN with time 0:00:00.
- Arithmetic: all compares are on the full field width using ">= modulus-1" wrap tests. Out-of-range values are unreachable, but if forced they wrap to 0 on the next increment.

Decomposition:
- Shared header/package watch_pkg holds:
  - Mode encodings MODE_RUN=2'b00, MODE_SET_MIN=2'b01, MODE_SET_HR=2'b10.
  - Field moduli SEC_MOD=60, MIN_MOD=60, HR_MOD=24.
  - Field widths 6/6/5.
- One sub-module, button_conditioner:
  - Contains the synchroniser, debounce counter, press pulse and auto-repeat.
  - Parameters DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES.
  - Ports userclock, reset, raw, level, press, fire.
  - Instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5):
- Rollover: reset, then RUN from 23:59:58, apply 2 ticks -> 23:59:59 then 00:00:00, mode=00 throughout.
- Set-mode entry: seconds=37, switches low, button0 held 10 cycles -> mode=01 at edge 7, seconds=0. Further ticks leave time unchanged and toggle blink.
- Minute inc/dec: in SET_MIN, minutes=59, one button2 press -> 0 with hours unchanged. Then one button3 press -> 59.
- Auto-repeat: in SET_HR, hours=22, button2 held 40 cycles -> 23 at edge 7, 0 at edge 27, 1 at edge 32, 2 at edge 37.
- Glitch rejection and simultaneous buttons:
  - A 3-cycle button2 glitch -> no change.
  - button2 and button3 raised in the same cycle -> no change.
- Override and reset:
  - In SET_MIN, switch2 raised in the same cycle as a button0 press -> mode=00 next edge and blink=0.
  - Reset asserted mid-auto-repeat -> 00:00:00, mode=00, no pulse on the cycle after release.
